// File: rtl/div_iter.sv
// div_iter: iterative 32-bit restoring divider for DIV/DIVU/REM/REMU with valid/ready handshakes
module div_iter #(
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [31:0] din1,
    input  logic [31:0] din2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] dout,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t      r_state;
    logic [32:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_div;
    logic [31:0] r_spec_res;
    logic [4:0]  r_cnt;
    logic        r_spec;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_is_rem;
    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic        w_dz;
    logic        w_ovf;
    logic [31:0] w_spec_res;
    logic [32:0] w_sh;
    logic [32:0] w_diff;
    logic [32:0] w_rem_nx;
    logic [31:0] w_quo_nx;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;
    logic [31:0] w_res;

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = (r_state == DONE);

    // Operand preparation at accept time: magnitudes, signs and the special-case result.
    // The special result is kept so the full-latency path can substitute it at the end.
    always_comb begin
        w_signed   = ~op[0];
        w_a_neg    = w_signed & din1[31];
        w_b_neg    = w_signed & din2[31];
        w_a_mag    = w_a_neg ? -din1 : din1;
        w_b_mag    = w_b_neg ? -din2 : din2;
        w_dz       = (din2 == 32'd0);
        w_ovf      = w_signed && (din1 == 32'h8000_0000) && (din2 == 32'hFFFF_FFFF);
        w_spec_res = w_dz ? (op[1] ? din1 : 32'hFFFF_FFFF) : (op[1] ? 32'd0 : 32'h8000_0000);
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        w_sh     = {r_rem[31:0], r_quo[31]};
        w_diff   = w_sh - {1'b0, r_div};
        w_rem_nx = w_diff[32] ? w_sh : w_diff;
        w_quo_nx = {r_quo[30:0], ~w_diff[32]};
        w_q_fix  = r_neg_q ? -w_quo_nx : w_quo_nx;
        w_r_fix  = r_neg_r ? -w_rem_nx[31:0] : w_rem_nx[31:0];
        w_res    = r_spec ? r_spec_res : (r_is_rem ? w_r_fix : w_q_fix);
    end

    // Control FSM and datapath registers; the result is loaded into dout on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_rem      <= '0;
            r_quo      <= '0;
            r_div      <= '0;
            r_spec_res <= '0;
            r_cnt      <= '0;
            r_spec     <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_is_rem   <= 1'b0;
            dout       <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_rem      <= '0;
                    r_quo      <= w_a_mag;
                    r_div      <= w_b_mag;
                    r_cnt      <= '0;
                    r_neg_q    <= w_a_neg ^ w_b_neg;
                    r_neg_r    <= w_a_neg;
                    r_is_rem   <= op[1];
                    r_spec     <= w_dz | w_ovf;
                    r_spec_res <= w_spec_res;
                    if (EARLY_OUT && (w_dz || w_ovf)) begin
                        dout    <= w_spec_res;
                        r_state <= DONE;
                    end else begin
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_rem <= w_rem_nx;
                    r_quo <= w_quo_nx;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        dout    <= w_res;
                        r_state <= DONE;
                    end
                end
                DONE: if (out_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: checks early-out and full-latency divider instances against an arithmetic reference
module tb_div_iter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [1:0]  op = '0;
    logic [31:0] din1 = '0;
    logic [31:0] din2 = '0;
    logic        ir1, ov1, b1, ir0, ov0, b0;
    logic [31:0] d1, d0;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    div_iter #(.EARLY_OUT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .op(op),
        .din1(din1), .din2(din2), .out_valid(ov1), .out_ready(out_ready), .dout(d1), .busy(b1)
    );
    div_iter #(.EARLY_OUT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .op(op),
        .din1(din1), .din2(din2), .out_valid(ov0), .out_ready(out_ready), .dout(d0), .busy(b0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
        if (o[0]) return o[1] ? a % b : a / b;
        sa = $signed(a);
        sb = $signed(b);
        return o[1] ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        bit          sp;
        int          k, l1, l0;
        exp = ref_res(o, a, b);
        sp  = (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        @(negedge clk);
        op = o; din1 = a; din2 = b; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; din1 = $urandom; din2 = $urandom; op = 2'($urandom);
        k = 1; l1 = 0; l0 = 0;
        while (k <= 40 && (l1 == 0 || l0 == 0)) begin
            if (l1 == 0 && ov1) l1 = k;
            if (l0 == 0 && ov0) l0 = k;
            if (l1 == 0 || l0 == 0) begin
                @(posedge clk); #1;
            end
            k++;
        end
        chk("lat_early", l1, sp ? 1 : 33);
        chk("lat_full", l0, 33);
        chk("res_early", d1, exp);
        chk("res_full", d0, exp);
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("hold_flags", {ov1, ov0, ir1, ir0}, 4'b1100);
            chk("hold_data", {d1, d0}, {exp, exp});
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        #1 chk("ready_in_hs", {ir1, ir0}, 2'b00);
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("after_hs", {ov1, ov0, ir1, ir0, b1, b0}, 6'b001100);
        chk("keep_dout", {d1, d0}, {exp, exp});
    endtask

    initial begin
        #3 chk("rst_state", {ov1, ov0, ir1, ir0, b1, b0, d1, d0}, {6'b001100, 64'd0});
        @(negedge clk) rst_n = 1'b1;
        run(2'b01, 32'd100, 32'd7);
        run(2'b11, 32'd100, 32'd7);
        run(2'b00, 32'hFFFF_FFF9, 32'd2);
        run(2'b10, 32'hFFFF_FFF9, 32'd2);
        run(2'b00, 32'd5, 32'd0);
        run(2'b11, 32'd5, 32'd0);
        run(2'b10, 32'hFFFF_FFF9, 32'd0);
        run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
        run(2'b01, 32'hFFFF_FFFF, 32'd1);
        run(2'b00, 32'h8000_0000, 32'd2);
        for (int i = 0; i < 30; i++) begin
            logic [31:0] a, b;
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 :
                ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            run(2'($urandom_range(0, 3)), a, b);
        end
        @(negedge clk);
        op = 2'b01; din1 = 32'd1000; din2 = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("abort_state", {ov1, ov0, ir1, ir0, b1, b0, d1, d0}, {6'b001100, 64'd0});
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_hold", {ov1, ov0, b1, b0}, 4'b0000);
        end
        #1 rst_n = 1'b1;
        run(2'b01, 32'd9, 32'd3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 SHALL provide parameter EARLY_OUT, default 1; when 1, divide-by-zero and signed-overflow cases complete in one cycle; when 0, they take the full iterative latency.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 SHALL have port din1  input  32  dividend.
REQ-008 SHALL have port din2  input  32  divisor.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port dout  output  32  result, registered.
REQ-012 SHALL have port busy  output  1  high when the block is not in IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, CALC and DONE.
REQ-014 SHALL drive in_ready high only in IDLE; busy = (state != IDLE).
REQ-015 SHALL accept a request in cycle N when in_valid & in_ready; op, din1 and din2 are captured at that edge and later input changes are ignored.
REQ-016 SHALL, for DIV/REM, convert operands to magnitudes (two's complement) before iteration; for DIVU/REMU, use raw operands.
REQ-017 SHALL perform restoring radix-2 division: one quotient bit per CALC cycle, 32 CALC cycles, 33-bit partial remainder.
REQ-018 SHALL enter DONE with out_valid high in cycle N+33 for normal operands.
REQ-019 SHALL, for DIV, negate the quotient when sign(din1) xor sign(din2) is set; for REM, give the remainder the sign of din1.
REQ-020 SHALL, on divisor == 0, return quotient 0xFFFFFFFF (DIV/DIVU) and remainder = din1 (REM/REMU).
REQ-021 SHALL, on DIV/REM with din1 = 0x80000000 and din2 = 0xFFFFFFFF, return quotient 0x80000000 and remainder 0.
REQ-022 SHALL, when EARLY_OUT = 1, go directly IDLE -> DONE for REQ-020/REQ-021 cases, with out_valid in cycle N+1.
REQ-023 SHALL hold out_valid and dout stable in DONE until out_ready is high, then return to IDLE on that edge.
REQ-024 SHALL keep in_ready low in DONE, even in a cycle where out_valid & out_ready; the earliest next accept is the cycle after the output handshake.
REQ-025 SHALL hold dout at its last value after the output handshake until the next result is loaded.
REQ-026 SHALL use a 5-bit iteration counter counting 0..31; CALC exits on count 31 without wrap-around to a 33rd iteration.

Reset
REQ-027 SHALL, while rst_n is low, force state = IDLE, out_valid = 0, dout = 0, busy = 0, in_ready = 1 after release, and counter = 0, independent of clk.
REQ-028 SHALL abort any in-flight CALC or DONE on reset; the aborted result is never presented.
REQ-029 SHALL accept a request in the first clk edge after rst_n deasserts if in_valid is high.

Verification
REQ-030 SHALL pass: DIVU din1=100, din2=7, accept at N -> out_valid at N+33, dout=14; REMU same operands -> dout=2.
REQ-031 SHALL pass: DIV din1=0xFFFFFFF9 (-7), din2=2 -> dout=0xFFFFFFFD (-3); REM same operands -> dout=0xFFFFFFFF (-1).
REQ-032 SHALL pass: DIV din1=5, din2=0, EARLY_OUT=1 -> out_valid at N+1, dout=0xFFFFFFFF; REMU din1=5, din2=0 -> dout=5.
REQ-033 SHALL pass: DIV din1=0x80000000, din2=0xFFFFFFFF -> dout=0x80000000; REM same operands -> dout=0; with EARLY_OUT=0 the same results appear at N+33.
REQ-034 SHALL pass: out_ready held low 5 cycles after out_valid -> dout and out_valid stable, in_ready=0, in_valid ignored; out_ready=1 -> IDLE on the next edge.
REQ-035 SHALL pass: rst_n pulsed low at CALC cycle 10 -> out_valid=0, dout=0, busy=0 immediately; no stale result afterwards; a new DIVU 9/3 completes with dout=3.
